// File: rtl/core_mul_seq.sv
// Sequential posit core multiplier.
// Forms the mantissa product one multiplier bit per cycle with shift-add.
// It then normalizes the product to [1,2) with the MSB set and adds the exponents.
module core_mul_seq #(
  parameter int unsigned N         = 16,
  parameter int unsigned ES        = 1,
  parameter int unsigned TE_SIZE   = ES + $clog2(N) + 1,
  parameter int unsigned MANT_SIZE = N - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TE_SIZE-1:0]       te1,
  input  logic [TE_SIZE-1:0]       te2,
  input  logic [MANT_SIZE-1:0]     mant1,
  input  logic [MANT_SIZE-1:0]     mant2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*MANT_SIZE-1:0]   mant_out,
  output logic [TE_SIZE-1:0]       te_out
);

  localparam int unsigned PW   = 2 * MANT_SIZE;
  localparam int unsigned CntW = $clog2(MANT_SIZE);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        mcand_q, mcand_d;
  logic [MANT_SIZE-1:0] mplier_q, mplier_d;
  logic [PW-1:0]        acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [TE_SIZE-1:0]   te_sum_q, te_sum_d;
  logic [PW-1:0]        mant_out_q, mant_out_d;
  logic [TE_SIZE-1:0]   te_out_q, te_out_d;

  logic [PW-1:0]        addend;
  logic [PW-1:0]        sum;

  // Next-state logic for the FSM and datapath; handshake outputs decoded from state.
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    te_sum_d   = te_sum_q;
    mant_out_d = mant_out_q;
    te_out_d   = te_out_q;
    in_ready   = (state_q == StIdle);
    out_valid  = (state_q == StDone);
    addend     = mplier_q[0] ? mcand_q : '0;
    // The accumulation for this cycle. On the last cycle it is the full product.
    sum        = acc_q + addend;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d  = {{MANT_SIZE{1'b0}}, mant1};
          mplier_d = mant2;
          te_sum_d = te1 + te2;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(MANT_SIZE - 1)) begin
          // The product lies in [1,4). Shift it so the MSB is set, and bump the exponent if it was >= 2.
          if (sum[PW-1]) begin
            mant_out_d = sum;
            te_out_d   = te_sum_q + TE_SIZE'(1);
          end else begin
            mant_out_d = sum << 1;
            te_out_d   = te_sum_q;
          end
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; an asynchronous reset drops any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      te_sum_q   <= '0;
      mant_out_q <= '0;
      te_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      te_sum_q   <= te_sum_d;
      mant_out_q <= mant_out_d;
      te_out_q   <= te_out_d;
    end
  end

  assign mant_out = mant_out_q;
  assign te_out   = te_out_q;

endmodule

// File: tb/tb_core_mul_seq.sv
// Directed bench for core_mul_seq (N=16: MANT_SIZE=14, TE_SIZE=6).
module tb_core_mul_seq;

  localparam int unsigned MS = 14;
  localparam int unsigned TS = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [TS-1:0] te1, te2;
  logic [MS-1:0] mant1, mant2;
  logic          out_valid;
  logic          out_ready;
  logic [2*MS-1:0] mant_out;
  logic [TS-1:0] te_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [MS-1:0]   m1;
    logic [MS-1:0]   m2;
    logic [TS-1:0]   t1;
    logic [TS-1:0]   t2;
    logic [2*MS-1:0] em;
    logic [TS-1:0]   et;
  } vec_t;

  vec_t vecs[7];

  core_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .te1       (te1),
    .te2       (te2),
    .mant1     (mant1),
    .mant2     (mant2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant_out  (mant_out),
    .te_out    (te_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present operands and leave at the negedge after the accepting edge.
  task automatic start_op(input vec_t v, input string name);
    @(negedge clk);
    in_valid = 1'b1;
    mant1 = v.m1; mant2 = v.m2; te1 = v.t1; te2 = v.t2;
    chk({name, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid. If chk_val is set, also compare the result.
  task automatic wait_result(input vec_t v, input bit chk_val, input string name);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({name, " latency"}, 64'(lat), 64'd14);
    if (chk_val) begin
      chk({name, " mant_out"}, 64'(mant_out), 64'(v.em));
      chk({name, " te_out"}, 64'(te_out), 64'(v.et));
    end
    chk({name, " in_ready in DONE"}, 64'(in_ready), 64'd0);
  endtask

  // Accept the result with a one-cycle out_ready pulse and check that the outputs hold in IDLE.
  task automatic release_out(input vec_t v, input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " idle out_valid"}, 64'(out_valid), 64'd0);
    chk({name, " idle in_ready"}, 64'(in_ready), 64'd1);
    chk({name, " idle hold"}, 64'({mant_out, te_out}), 64'({v.em, v.et}));
  endtask

  initial begin
    vec_t a, b, ill;
    logic [2*MS+TS+1:0] snap;

    vecs[0] = '{14'h2000, 14'h2000, 6'h00, 6'h00, 28'h8000000, 6'h00};
    vecs[1] = '{14'h3000, 14'h3000, 6'h03, 6'h3B, 28'h9000000, 6'h3F};
    vecs[2] = '{14'h3FFF, 14'h3FFF, 6'h00, 6'h00, 28'hFFF8001, 6'h01};
    vecs[3] = '{14'h3000, 14'h3000, 6'h1F, 6'h01, 28'h9000000, 6'h21};
    vecs[4] = '{14'h2000, 14'h3FFF, 6'h20, 6'h3F, 28'hFFFC000, 6'h1F};
    vecs[5] = '{14'h2001, 14'h2001, 6'h05, 6'h07, 28'h8008002, 6'h0C};
    vecs[6] = '{14'h2800, 14'h3000, 6'h00, 6'h00, 28'hF000000, 6'h00};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    te1 = '0; te2 = '0; mant1 = '0; mant2 = '0;
    #12;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset outputs", 64'({mant_out, te_out}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i], $sformatf("vec%0d", i));
      wait_result(vecs[i], 1'b1, $sformatf("vec%0d", i));
      release_out(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result stays put and new input is refused while DONE waits
    a = '{14'h3FFF, 14'h3FFF, 6'h02, 6'h03, 28'hFFF8001, 6'h06};
    b = '{14'h2000, 14'h2000, 6'h01, 6'h01, 28'h8000000, 6'h02};
    start_op(a, "bp");
    wait_result(a, 1'b1, "bp");
    in_valid = 1'b1;
    mant1 = b.m1; mant2 = b.m2; te1 = b.t1; te2 = b.t2;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      snap = {mant_out, te_out, out_valid, in_ready};
      chk($sformatf("bp hold%0d", c), 64'(snap), 64'({a.em, a.et, 1'b1, 1'b0}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp released out_valid", 64'(out_valid), 64'd0);
    chk("bp released in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp next accepted", 64'(in_ready), 64'd0);
    wait_result(b, 1'b1, "bp next");
    release_out(b, "bp next");

    // Asynchronous reset at cnt=7 clears everything immediately
    start_op(vecs[2], "rst mid");
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst mid out_valid", 64'(out_valid), 64'd0);
    chk("rst mid in_ready", 64'(in_ready), 64'd1);
    chk("rst mid outputs", 64'({mant_out, te_out}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    start_op(vecs[3], "after rst");
    wait_result(vecs[3], 1'b1, "after rst");
    release_out(vecs[3], "after rst");

    // An illegal mantissa (MSB clear) must still finish on schedule
    ill = '{14'h0001, 14'h0001, 6'h00, 6'h00, 28'h0, 6'h0};
    start_op(ill, "illegal");
    wait_result(ill, 1'b0, "illegal");
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("illegal idle", 64'(in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
